// File: rtl/if_prefetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_prefetch_stage_if #(
    parameter int IMEM_AW = 11
);
    logic               o_imem_req;
    logic [IMEM_AW-1:0] o_imem_addr;
    logic               i_imem_gnt;
    logic               i_imem_rvalid;
    logic [31:0]        i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata
    );
endinterface

// File: rtl/if_prefetch_stage_fifo.sv
// Ring-buffer FIFO with flush; pointers/count reset asynchronously, storage is not reset.
module if_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // flush dominates both push and pop issued in the same cycle
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited in-order imem fetch into a prefetch queue for decode.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          IMEM_AW    = 11
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_stall,
    if_prefetch_stage_if.master        imem,
    output logic                       o_valid,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic          rst_q;
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_next;
    fetch_state_t  state;
    fetch_state_t  state_next;

    logic          grant;
    logic          rvalid;
    logic          credit_ok;
    logic          keep_resp;
    logic          pop;
    logic [31:0]   addr_head;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign rvalid    = imem.i_imem_rvalid;
    assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < DEPTH_SUM;
    assign imem.o_imem_req  = !rst_q && !i_redirect && credit_ok;
    assign imem.o_imem_addr = fetch_pc[IMEM_AW+1:2];
    assign grant     = imem.o_imem_req && imem.i_imem_gnt;

    // responses are kept only outside FLUSH; a redirect flush in the same cycle wins anyway
    assign keep_resp  = rvalid && (state == RUN);
    assign push_entry = '{pc: addr_head, instr: imem.i_imem_rdata};
    assign pop        = o_valid && !i_stall;

    assign o_valid = (count != '0);
    assign o_pc    = o_valid ? head_entry.pc    : 32'h0;
    assign o_instr = o_valid ? head_entry.instr : 32'h0;

    // addresses of granted requests; its occupancy is the in-flight count
    if_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_addr_q (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (grant),
        .pop   (rvalid),
        .flush (1'b0),
        .din   (fetch_pc),
        .head  (addr_head),
        .count (inflight)
    );

    if_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (keep_resp),
        .pop   (pop),
        .flush (i_redirect),
        .din   (push_entry),
        .head  (head_entry),
        .count (count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            fetch_pc <= i_redirect_pc & 32'hFFFF_FFFC;
        end else if (grant) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= RUN;
            discard <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    // every request still outstanding after a redirect cycle is stale
    always_comb begin
        discard_next = discard;
        state_next   = state;
        if (i_redirect) begin
            discard_next = inflight - (rvalid ? CNT_ONE : '0);
        end else if (rvalid && (state == FLUSH)) begin
            discard_next = discard - CNT_ONE;
        end
        state_next = (discard_next != '0) ? FLUSH : RUN;
    end

    a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
        !(rvalid && (inflight == '0)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized and directed bench for if_prefetch_stage against a program-order reference model.
module tb_if_prefetch_stage;
    import if_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          AW    = 11;
    localparam logic [31:0] RPC1  = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, redirect, stall;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] instr, pc;
    logic        redirect2, stall2;
    logic [31:0] redirect_pc2;
    logic        valid2;
    logic [31:0] instr2, pc2;

    if_prefetch_stage_if #(.IMEM_AW(AW)) bus ();
    if_prefetch_stage_if #(.IMEM_AW(AW)) bus2 ();

    if_prefetch_stage #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH), .IMEM_AW(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_stall(stall), .imem(bus), .o_valid(valid), .o_instr(instr), .o_pc(pc));

    if_prefetch_stage #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH), .IMEM_AW(AW)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
        .i_stall(stall2), .imem(bus2), .o_valid(valid2), .o_instr(instr2), .o_pc(pc2));

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } resp_t;

    resp_t       rq[$];
    int          edge_n, last_due, lat, gnt_pct, pops;
    int          total, bad;
    logic [31:0] exp_pc;
    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return NOP_INSTR ^ {a, 10'h2A5, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock of dut stimulus, imem model and program-order checking
    task automatic step(input logic rst_v, input logic stall_v, input logic redir_v,
                        input logic [31:0] rpc_v);
        int due;
        @(negedge clk);
        rst = rst_v; stall = stall_v; redirect = redir_v; redirect_pc = rpc_v;
        bus.i_imem_gnt = ($urandom_range(99) < gnt_pct);
        bus.i_imem_rdata = $urandom;
        bus.i_imem_rvalid = 1'b0;
        if (rst_v) begin
            rq.delete();
        end else if (rq.size() != 0 && rq[0].due == edge_n) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = mem_word(rq[0].addr);
            void'(rq.pop_front());
        end
        #1;
        s_valid = valid; s_pc = pc; s_instr = instr; s_req = bus.o_imem_req;
        if (rst_v) begin
            exp_pc = RPC1;
            last_due = 0;
        end else begin
            if (redir_v) begin
                exp_pc = rpc_v & 32'hFFFF_FFFC;
            end else if (valid && !stall_v) begin
                check_eq("pop_pc", pc, exp_pc);
                check_eq("pop_instr", instr, mem_word(exp_pc[AW+1:2]));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (bus.o_imem_req && bus.i_imem_gnt) begin
                due = (edge_n + lat > last_due + 1) ? edge_n + lat : last_due + 1;
                rq.push_back('{addr: bus.o_imem_addr, due: due});
                last_due = due;
                check_eq("outstanding_le_depth", 32'(rq.size() <= DEPTH), 32'd1);
            end
        end
        edge_n++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // fixed-latency (1) always-granting imem for the second instance
    logic          g2;
    logic [AW-1:0] g2_addr;
    initial begin
        g2 = 1'b0; g2_addr = '0;
        bus2.i_imem_gnt = 1'b1; bus2.i_imem_rvalid = 1'b0; bus2.i_imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                g2 = 1'b0;
                bus2.i_imem_rvalid = 1'b0;
            end else begin
                bus2.i_imem_rvalid = g2;
                bus2.i_imem_rdata  = mem_word(g2_addr);
                g2      = bus2.o_imem_req;
                g2_addr = bus2.o_imem_addr;
            end
        end
    end

    initial begin
        int first, vcnt, n, p0, k2;
        logic [31:0] seq [8];
        logic [31:0] first_pc;
        logic [31:0] exp2 [3];

        total = 0; bad = 0; edge_n = 0; last_due = 0; pops = 0;
        lat = 1; gnt_pct = 100; exp_pc = RPC1;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        redirect2 = 1'b0; stall2 = 1'b0; redirect_pc2 = 32'h0;
        bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = 32'h0;

        // reset values, fill latency and one-per-cycle streaming
        do_reset();
        check_eq("rst_valid", s_valid, 1'b0);
        check_eq("rst_pc", s_pc, 32'h0);
        check_eq("rst_instr", s_instr, 32'h0);
        check_eq("rst_req", s_req, 1'b0);
        first = 0; vcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 1) check_eq("req_low_at_release", s_req, 1'b0);
            if (i == 2) check_eq("req_after_release", s_req, 1'b1);
            if (first != 0) vcnt += int'(s_valid);
            if (s_valid && first == 0) first = i;
        end
        check_eq("first_valid_cycle", first, 4);
        check_eq("stream_valid_cycles", vcnt, 16);

        // stall fills the queue and holds the head
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("stall_head_pc", s_pc, 32'h0);
        check_eq("stall_valid", s_valid, 1'b1);
        check_eq("stall_req_dropped", s_req, 1'b0);
        check_eq("stall_no_outstanding", rq.size(), 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (s_valid && n < 8) begin seq[n] = s_pc; n++; end
        end
        check_eq("stall_release_pops", 32'(n >= 5), 32'd1);
        for (int k = 0; k < 5; k++) check_eq("stall_release_order", seq[k], 32'(4 * k));

        // latency 3, redirect with three requests in flight
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && rq.size() != 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("inflight_before_redirect", rq.size(), 3);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        first = 0; first_pc = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (s_valid && first == 0) begin first = i; first_pc = s_pc; end
        end
        check_eq("redirect_first_valid_cycle", first, 5);
        check_eq("redirect_first_pc", first_pc, 32'h0000_0100);

        // redirect while stalled: flush wins, target low bits dropped
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("flush_with_stall_valid", s_valid, 1'b0);
        first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && first_pc == 32'hDEAD_BEEF; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (s_valid) first_pc = s_pc;
        end
        check_eq("flush_stall_next_pc", first_pc, 32'h0000_0200);

        // PC wrap on the second instance
        exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC; exp2[2] = 32'h0000_0000;
        do_reset();
        k2 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (valid2 && k2 < 3) begin
                check_eq("wrap_pc", pc2, exp2[k2]);
                check_eq("wrap_instr", instr2, mem_word(exp2[k2][AW+1:2]));
                k2++;
            end
        end
        check_eq("wrap_pops", k2, 3);

        // reset mid-stream with work queued and in flight
        do_reset();
        lat = 3;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("midrst_pre_valid", s_valid, 1'b1);
        check_eq("midrst_pre_inflight", 32'(rq.size() > 0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("midrst_valid", s_valid, 1'b0);
        check_eq("midrst_req", s_req, 1'b0);
        check_eq("midrst_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 12 && first_pc == 32'hDEAD_BEEF; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (s_valid) first_pc = s_pc;
        end
        check_eq("midrst_refetch_pc", first_pc, RPC1);

        // randomized traffic: grants, stalls, redirects, varying latency
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            lat = 1 + ph;
            gnt_pct = 70;
            p0 = pops;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(99) < 4)
                    step(1'b0, ($urandom_range(99) < 25), 1'b1, $urandom);
                else
                    step(1'b0, ($urandom_range(99) < 25), 1'b0, 32'h0);
            end
            check_eq("random_progress", 32'(pops - p0 > 200), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
